// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: multi-cycle load/store unit with valid/ready request and response
// channels and a word-aligned, byte-strobed memory port with timeout detection.
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_req_valid / o_req_ready         request handshake from EXU/IDU
//   i_req_opt                         [3]=store [2]=unsigned [1:0]=size (B/H/W/D)
//   i_req_addr, i_req_wdata           byte address, LSB-justified store data
//   o_resp_valid / i_resp_ready       response handshake to WBU
//   o_resp_rdata, o_resp_err          extended load data, misalign/timeout flag
//   o_mem_req_valid / i_mem_req_ready memory request handshake
//   o_mem_we, o_mem_addr              write enable, beat-aligned address
//   o_mem_wdata, o_mem_wstrb          lane-shifted store data and byte strobes
//   i_mem_resp_valid, i_mem_rdata     read data / write ack (always accepted)
module lsu_bus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [3:0]          i_req_opt,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   o_resp_rdata,
    output logic                o_resp_err,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        r_state;
    logic              r_store;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [NB-1:0]     r_mem_wstrb;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [OFF_W-1:0]  w_off;
    logic              w_mis;
    logic [NB-1:0]     w_smask;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_lmask;
    logic              w_sign;
    logic [DATA_W-1:0] w_load;

    assign w_off = i_req_addr[OFF_W-1:0];

    // Doubleword on a 32-bit bus has no legal alignment, so it always faults.
    always_comb begin
        w_mis = 1'b0;
        unique case (i_req_opt[1:0])
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = w_off[0];
            2'd2:    w_mis = (w_off[1:0] != 2'b00);
            default: w_mis = (DATA_W == 32) || (w_off != '0);
        endcase
    end

    always_comb begin
        w_smask = '0;
        unique case (i_req_opt[1:0])
            2'd0:    w_smask = NB'(1);
            2'd1:    w_smask = NB'(3);
            2'd2:    w_smask = NB'(15);
            default: w_smask = '1;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, keep the op size,
    // then fill the upper bits with the sign bit unless unsigned.
    assign w_shift = i_mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_lmask = '1;
        w_sign  = w_shift[DATA_W-1];
        unique case (r_size)
            2'd0: begin
                w_lmask = DATA_W'(8'hFF);
                w_sign  = w_shift[7];
            end
            2'd1: begin
                w_lmask = DATA_W'(16'hFFFF);
                w_sign  = w_shift[15];
            end
            2'd2: begin
                w_lmask = DATA_W'(32'hFFFF_FFFF);
                w_sign  = w_shift[31];
            end
            default: begin
                w_lmask = '1;
                w_sign  = w_shift[DATA_W-1];
            end
        endcase
    end

    assign w_load = (w_shift & w_lmask)
                  | ((!r_uns && w_sign) ? ~w_lmask : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_mem_we    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store     <= i_req_opt[3];
                        r_uns       <= i_req_opt[2];
                        r_size      <= i_req_opt[1:0];
                        r_off       <= w_off;
                        r_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_mem_wdata <= i_req_wdata << {w_off, 3'b000};
                        r_mem_wstrb <= i_req_opt[3] ? (w_smask << w_off) : '0;
                        r_mem_we    <= i_req_opt[3];
                        r_rdata     <= '0;
                        r_err       <= w_mis;
                        r_state     <= w_mis ? S_RESP : S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing on the final allowed cycle beats the timeout.
                    if (i_mem_resp_valid) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_store ? '0 : w_load;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (i_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_req_ready     = (r_state == S_IDLE);
    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_resp_valid    = (r_state == S_RESP);
    assign o_resp_rdata    = r_rdata;
    assign o_resp_err      = r_err;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_wstrb     = r_mem_wstrb;

endmodule
